cpu_readback: RTL and testbench
===============================

CPU_READBACK -- requirements
Module: cpu_readback

Interface
REQ-001 Parameter MAIN_BASE, default 24'h3FA700: byte address of the main frame buffer in CPU space; even.
REQ-002 Parameter ALT_BASE, default 24'h3F2700: byte address of the alternate frame buffer in CPU space; even.
REQ-003 Parameter WIN_BYTES, default 21888: size in bytes of each buffer window.
REQ-004 Port pixClk, input, 1: the single clock, 25.175MHz pixel clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Port seq, input, 3: pixel sequence phase, hCount[2:0].
REQ-007 Port cpuAddr, input, 23 ([23:1]): CPU word address.
REQ-008 Ports ncpuAS, ncpuUDS, ncpuLDS, cpuRnW, input, 1 each: asynchronous 68000 strobes and direction.
REQ-009 Port cpuDataOut, output, 16: readback data to the CPU bus.
REQ-010 Port cpuDataOE, output, 1: high enables the external cpuDataOut drivers.
REQ-011 Port ncpuDTACK, output, 1: active-low data acknowledge, qualified externally by cpuDataOE.
REQ-012 Port rdAddr, output, 15: VRAM byte address for a CPU read.
REQ-013 Port nrdOE, output, 1: active-low VRAM read request; the top-level mux gives it priority only in the CPU slots.
REQ-014 Port rdBufSel, output, 1: 0 selects the main chip (CE0), 1 selects the alt chip (CE1).
REQ-015 Port vramDataIn, input, 8: VRAM data bus.

Function
REQ-016 ncpuAS, ncpuUDS and ncpuLDS SHALL pass through a 2-flop synchronizer; cpuAddr and cpuRnW SHALL be sampled on the cycle synchronized AS is first seen low.
REQ-017 A cycle SHALL be a hit when RnW=1, at least one synchronized data strobe is low, and byte address {cpuAddr,0} minus MAIN_BASE (or ALT_BASE) is in [0, WIN_BYTES-1]; a main-window hit SHALL set rdBufSel=0 and an alt-window hit SHALL set rdBufSel=1.
REQ-018 The FSM states SHALL be IDLE, FETCH_HI, FETCH_LO, ACK and WAIT_NEG.
REQ-019 From IDLE, a hit SHALL go to FETCH_HI if UDS is low, else to FETCH_LO; a non-hit (write or out of window) SHALL go to WAIT_NEG.
REQ-020 A fetch SHALL occur only in a cycle where seq is 3'd3 or 3'd7; in that cycle nrdOE=0 and rdAddr is set to the window offset (+1 for the low byte).
REQ-021 vramDataIn SHALL be captured on the edge that ends the slot cycle: into cpuDataOut[15:8] for FETCH_HI and into [7:0] for FETCH_LO.
REQ-022 After capture, FETCH_HI SHALL go to FETCH_LO if LDS is low, else to ACK; FETCH_LO SHALL go to ACK.
REQ-023 In ACK, cpuDataOE=1 and ncpuDTACK=0 SHALL hold until synchronized AS is high, then the FSM goes to IDLE and both outputs are released on that edge.
REQ-024 WAIT_NEG SHALL return to IDLE when synchronized AS is high; no outputs are asserted in WAIT_NEG.
REQ-025 A byte lane that is not strobed SHALL read 8'h00.
REQ-026 nrdOE SHALL be low for exactly one cycle per byte fetched and never outside a slot.
REQ-027 If AS deasserts during FETCH_HI or FETCH_LO, the FSM SHALL abort to IDLE without asserting DTACK, and any pending slot request is dropped.
REQ-028 A new AS assertion SHALL only be accepted from IDLE.
REQ-029 Latency from synchronized AS low to DTACK SHALL be at most 10 cycles for a word read.

Reset
REQ-030 While reset is high, the FSM SHALL be in IDLE and all of the following SHALL hold: nrdOE=1, ncpuDTACK=1, cpuDataOE=0, cpuDataOut=0, rdAddr=0, rdBufSel=0, synchronizer flops=1.
REQ-031 Reset asserted mid-operation SHALL abandon the cycle on the next edge; after release the block SHALL wait for AS high before accepting a new cycle.

Structure
REQ-032 Package sevga_pkg SHALL hold the FSM state enum, the slot constants 3'd3 and 3'd7, and the buffer default bases and size.
REQ-033 The 2-flop synchronizer SHALL be one sub-module, cpusync, instantiated once per strobe.
REQ-034 The window compare and offset SHALL be computed at 24-bit width and truncated to 15 bits only after the range check.

Verification
REQ-035 Word read at cpuAddr 23'h1FD380 (byte 3FA700), VRAM[0]=A5, VRAM[1]=3C -> cpuDataOut=16'hA53C, rdBufSel=0, DTACK within 10 cycles, two nrdOE pulses, each in a seq 3/7 cycle.
REQ-036 LDS-only read at byte 3F2701 (alt), VRAM[1]=7E -> cpuDataOut=16'h007E, rdBufSel=1, one nrdOE pulse.
REQ-037 Write, or read at byte 3FA700+21888 -> no nrdOE, no DTACK, FSM returns to IDLE after AS rises.
REQ-038 AS released after the first byte fetch of a word read -> no DTACK, no second nrdOE, FSM in IDLE.
REQ-039 Reset pulsed in ACK -> DTACK and cpuDataOE high/low respectively on the next edge; an AS still low is ignored until it rises.
REQ-040 Back-to-back reads with AS high for 3 cycles between them -> both acknowledged with correct data, no overlap of ACK states.

Source files
------------

// File: rtl/sevga_pkg.sv
// rtl/sevga_pkg.sv - shared types and constants for the CPU readback path
// Holds the readback FSM state enum, the two CPU slot phases of the pixel
// sequence, and the default frame buffer bases and window size.
package sevga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    ACK,
    WAIT_NEG
  } rb_state_t;

  // Pixel sequence phases in which the CPU owns the VRAM bus.
  localparam logic [2:0] SLOT_A = 3'd3;
  localparam logic [2:0] SLOT_B = 3'd7;

  localparam logic [23:0] MAIN_BASE_DEF = 24'h3FA700;
  localparam logic [23:0] ALT_BASE_DEF  = 24'h3F2700;
  localparam int          WIN_BYTES_DEF = 21888;

  function automatic logic is_slot(input logic [2:0] s);
    return (s == SLOT_A) || (s == SLOT_B);
  endfunction

endpackage

// File: rtl/cpusync.sv
// rtl/cpusync.sv - two-flop synchronizer for one asynchronous 68000 strobe
// Ports: i_clk (pixel clock), i_reset (sync, active-high, flops go to 1),
//        i_async (raw active-low strobe), o_sync (synchronized strobe).
module cpusync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Strobes are active-low, so the idle/reset value is 1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/cpu_readback.sv
// rtl/cpu_readback.sv - 68000 read access to the main/alt frame buffers in VRAM
// Ports: pixClk/reset (clock, sync active-high reset); seq (pixel phase);
//        cpuAddr/ncpuAS/ncpuUDS/ncpuLDS/cpuRnW (async CPU bus inputs);
//        cpuDataOut/cpuDataOE/ncpuDTACK (CPU bus response);
//        rdAddr/nrdOE/rdBufSel/vramDataIn (VRAM read port, slot-qualified).
module cpu_readback
  import sevga_pkg::*;
#(
  parameter logic [23:0] MAIN_BASE = MAIN_BASE_DEF,
  parameter logic [23:0] ALT_BASE  = ALT_BASE_DEF,
  parameter int          WIN_BYTES = WIN_BYTES_DEF
) (
  input  logic        pixClk,
  input  logic        reset,
  input  logic [2:0]  seq,
  input  logic [23:1] cpuAddr,
  input  logic        ncpuAS,
  input  logic        ncpuUDS,
  input  logic        ncpuLDS,
  input  logic        cpuRnW,
  output logic [15:0] cpuDataOut,
  output logic        cpuDataOE,
  output logic        ncpuDTACK,
  output logic [14:0] rdAddr,
  output logic        nrdOE,
  output logic        rdBufSel,
  input  logic [7:0]  vramDataIn
);

  localparam logic [23:0] WIN = 24'(WIN_BYTES);

  logic w_as_s;
  logic w_uds_s;
  logic w_lds_s;

  cpusync u_sync_as  (.i_clk(pixClk), .i_reset(reset), .i_async(ncpuAS),  .o_sync(w_as_s));
  cpusync u_sync_uds (.i_clk(pixClk), .i_reset(reset), .i_async(ncpuUDS), .o_sync(w_uds_s));
  cpusync u_sync_lds (.i_clk(pixClk), .i_reset(reset), .i_async(ncpuLDS), .o_sync(w_lds_s));

  // Window decode at full 24-bit width; an address below the base wraps to a
  // large unsigned offset and fails the range check naturally.
  logic [23:0] w_byte_addr;
  logic [23:0] w_main_off;
  logic [23:0] w_alt_off;
  logic        w_main_hit;
  logic        w_alt_hit;
  logic        w_hit;
  logic [14:0] w_off;
  logic        w_next_slot;

  assign w_byte_addr = {cpuAddr, 1'b0};
  assign w_main_off  = w_byte_addr - MAIN_BASE;
  assign w_alt_off   = w_byte_addr - ALT_BASE;
  assign w_main_hit  = (w_main_off < WIN);
  assign w_alt_hit   = (w_alt_off < WIN);
  assign w_hit       = cpuRnW && (!w_uds_s || !w_lds_s) && (w_main_hit || w_alt_hit);
  assign w_off       = w_main_hit ? w_main_off[14:0] : w_alt_off[14:0];
  // The request is raised one cycle ahead so the registered rdAddr is stable
  // for the whole slot cycle.
  assign w_next_slot = is_slot(seq + 3'd1);

  rb_state_t   r_state;
  logic [15:0] r_data;
  logic        r_oe;
  logic        r_dtack_n;
  logic        r_req;
  logic [14:0] r_rdaddr;
  logic        r_bufsel;
  logic [14:0] r_off;
  logic        r_lds_act;
  logic        r_need_neg;
  logic [1:0]  r_settle;

  always_ff @(posedge pixClk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_data     <= 16'h0000;
      r_oe       <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_req      <= 1'b0;
      r_rdaddr   <= 15'd0;
      r_bufsel   <= 1'b0;
      r_off      <= 15'd0;
      r_lds_act  <= 1'b0;
      r_need_neg <= 1'b1;
      r_settle   <= 2'd2;
    end else begin
      // The synchronizer holds its reset value for two edges; an AS that is
      // still low from before reset must not look like a released bus.
      if (r_settle != 2'd0) begin
        r_settle <= r_settle - 2'd1;
      end

      case (r_state)
        IDLE: begin
          if (r_need_neg) begin
            if (w_as_s && (r_settle == 2'd0)) begin
              r_need_neg <= 1'b0;
            end
          end else if (!w_as_s) begin
            if (w_hit) begin
              r_off     <= w_off;
              r_bufsel  <= !w_main_hit;
              r_data    <= 16'h0000;
              r_lds_act <= !w_lds_s;
              r_req     <= w_next_slot;
              if (!w_uds_s) begin
                r_state  <= FETCH_HI;
                r_rdaddr <= w_off;
              end else begin
                r_state  <= FETCH_LO;
                r_rdaddr <= w_off | 15'd1;
              end
            end else begin
              r_state <= WAIT_NEG;
            end
          end
        end

        FETCH_HI, FETCH_LO: begin
          if (w_as_s) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end else if (r_req && is_slot(seq)) begin
            r_req <= 1'b0;
            if (r_state == FETCH_HI) begin
              r_data[15:8] <= vramDataIn;
              if (r_lds_act) begin
                r_state  <= FETCH_LO;
                r_rdaddr <= r_off | 15'd1;
              end else begin
                r_state   <= ACK;
                r_oe      <= 1'b1;
                r_dtack_n <= 1'b0;
              end
            end else begin
              r_data[7:0] <= vramDataIn;
              r_state     <= ACK;
              r_oe        <= 1'b1;
              r_dtack_n   <= 1'b0;
            end
          end else begin
            r_req <= w_next_slot;
          end
        end

        ACK: begin
          if (w_as_s) begin
            r_state   <= IDLE;
            r_oe      <= 1'b0;
            r_dtack_n <= 1'b1;
          end
        end

        WAIT_NEG: begin
          if (w_as_s) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpuDataOut = r_data;
  assign cpuDataOE  = r_oe;
  assign ncpuDTACK  = r_dtack_n;
  assign rdAddr     = r_rdaddr;
  assign rdBufSel   = r_bufsel;
  // Gating with the live slot phase guarantees no read strobe leaks outside
  // a CPU slot even if seq does not advance as predicted.
  assign nrdOE      = !(r_req && is_slot(seq));

endmodule

// File: tb/tb_cpu_readback.sv
// tb/tb_cpu_readback.sv - scoreboard bench for cpu_readback
module tb_cpu_readback;
  import sevga_pkg::*;

  logic        pixClk = 1'b0;
  logic        reset;
  logic [2:0]  seq;
  logic [23:1] cpuAddr;
  logic        ncpuAS, ncpuUDS, ncpuLDS, cpuRnW;
  logic [15:0] cpuDataOut;
  logic        cpuDataOE, ncpuDTACK, nrdOE, rdBufSel;
  logic [14:0] rdAddr;
  logic [7:0]  vramDataIn;

  logic [7:0] main_mem [0:255];
  logic [7:0] alt_mem  [0:255];

  cpu_readback dut (
    .pixClk(pixClk), .reset(reset), .seq(seq), .cpuAddr(cpuAddr),
    .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS), .ncpuLDS(ncpuLDS), .cpuRnW(cpuRnW),
    .cpuDataOut(cpuDataOut), .cpuDataOE(cpuDataOE), .ncpuDTACK(ncpuDTACK),
    .rdAddr(rdAddr), .nrdOE(nrdOE), .rdBufSel(rdBufSel), .vramDataIn(vramDataIn)
  );

  assign vramDataIn = rdBufSel ? alt_mem[rdAddr[7:0]] : main_mem[rdAddr[7:0]];

  always #20 pixClk = ~pixClk;

  initial begin
    seq = 3'd0;
    forever begin
      @(posedge pixClk);
      #1 seq = seq + 3'd1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic        sel;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic ack_prev = 1'b0;
  int   pulse_cnt = 0;
  logic [14:0] last_rdaddr = 15'd0;

  // Monitor: every read strobe must fall in a slot; every new acknowledge
  // is matched against the oldest queued expectation.
  always @(negedge pixClk) begin
    if (reset === 1'b0) begin
      if (nrdOE === 1'b0) begin
        pulse_cnt++;
        last_rdaddr = rdAddr;
        check("nrdoe_in_slot", {31'd0, is_slot(seq)}, 32'd1);
      end
      if (!ncpuDTACK && cpuDataOE && !ack_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got data %0h expected no acknowledge", cpuDataOut);
        end else begin
          mon_e = sb_q.pop_front();
          check("ack_data", 32'(cpuDataOut), 32'(mon_e.data));
          check("ack_bufsel", 32'(rdBufSel), 32'(mon_e.sel));
        end
      end
    end
    ack_prev = (ncpuDTACK === 1'b0) && (cpuDataOE === 1'b1);
  end

  task automatic release_bus();
    ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1; cpuRnW = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 with AS high for 3 cycles.
  task automatic bus_cycle(input string tag, input logic [23:0] byte_addr, input logic rnw,
                           input logic uds, input logic lds, input logic exp_ack,
                           input logic [15:0] exp_data, input logic exp_sel,
                           input int exp_pulses, input logic [14:0] exp_last);
    int n;
    int p0;
    logic saw;
    p0 = pulse_cnt;
    if (exp_ack) sb_q.push_back({exp_data, exp_sel});
    cpuAddr = byte_addr[23:1]; cpuRnW = rnw;
    ncpuAS = 1'b0; ncpuUDS = !uds; ncpuLDS = !lds;
    if (exp_ack) begin
      n = 0;
      while (ncpuDTACK !== 1'b0 && n < 40) begin
        @(negedge pixClk); n++;
      end
      check({tag, "_latency"}, 32'(n <= 12), 32'd1);
    end else begin
      saw = 1'b0;
      repeat (12) begin
        @(negedge pixClk);
        if (ncpuDTACK === 1'b0) saw = 1'b1;
      end
      check({tag, "_no_dtack"}, 32'(saw), 32'd0);
    end
    @(posedge pixClk); #1;
    release_bus();
    repeat (3) @(posedge pixClk);
    #1;
    check({tag, "_dtack_released"}, 32'(ncpuDTACK), 32'd1);
    check({tag, "_idle"}, 32'(dut.r_state), 32'(IDLE));
    check({tag, "_pulses"}, 32'(pulse_cnt - p0), 32'(exp_pulses));
    if (exp_pulses > 0) check({tag, "_rdaddr"}, 32'(last_rdaddr), 32'(exp_last));
  endtask

  int n;
  int p0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      main_mem[i] = 8'h00;
      alt_mem[i]  = 8'h00;
    end
    main_mem[0] = 8'hA5; main_mem[1] = 8'h3C;
    main_mem[2] = 8'h5A; main_mem[3] = 8'hC3;
    main_mem[8'h7E] = 8'h11; main_mem[8'h7F] = 8'h22;
    alt_mem[0] = 8'h96; alt_mem[1] = 8'h7E;

    reset = 1'b1; cpuAddr = '0; release_bus();
    repeat (3) @(posedge pixClk);
    @(negedge pixClk);
    check("rst_nrdoe", 32'(nrdOE), 32'd1);
    check("rst_dtack", 32'(ncpuDTACK), 32'd1);
    check("rst_oe", 32'(cpuDataOE), 32'd0);
    check("rst_data", 32'(cpuDataOut), 32'd0);
    check("rst_rdaddr", 32'(rdAddr), 32'd0);
    check("rst_bufsel", 32'(rdBufSel), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_sync", 32'(dut.u_sync_as.o_sync), 32'd1);
    @(posedge pixClk); #1 reset = 1'b0;
    repeat (4) @(posedge pixClk);
    #1;

    bus_cycle("word_main", 24'h3FA700, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA53C, 1'b0, 2, 15'd1);
    bus_cycle("lds_alt",   24'h3F2701, 1'b1, 1'b0, 1'b1, 1'b1, 16'h007E, 1'b1, 1, 15'd1);
    bus_cycle("uds_main",  24'h3FA702, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5A00, 1'b0, 1, 15'd2);
    bus_cycle("word_alt",  24'h3F2700, 1'b1, 1'b1, 1'b1, 1'b1, 16'h967E, 1'b1, 2, 15'd1);
    bus_cycle("last_word", 24'h3FFC7E, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1122, 1'b0, 2, 15'h557F);
    bus_cycle("write",     24'h3FA700, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 15'd0);
    bus_cycle("past_end",  24'h3FFC80, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 15'd0);
    bus_cycle("below_alt", 24'h3F26FE, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 15'd0);

    // Abort: AS released right after the first byte fetch.
    p0 = pulse_cnt;
    cpuAddr = 23'h1FD380; cpuRnW = 1'b1;
    ncpuAS = 1'b0; ncpuUDS = 1'b0; ncpuLDS = 1'b0;
    n = 0;
    while (pulse_cnt == p0 && n < 40) begin
      @(negedge pixClk); #1; n++;
    end
    check("abort_first_pulse", 32'(pulse_cnt - p0), 32'd1);
    @(posedge pixClk); #1;
    release_bus();
    repeat (8) @(posedge pixClk);
    #1;
    check("abort_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("abort_idle", 32'(dut.r_state), 32'(IDLE));
    check("abort_dtack", 32'(ncpuDTACK), 32'd1);

    // Reset while acknowledging; AS held low across reset must be ignored.
    sb_q.push_back({16'hA53C, 1'b0});
    cpuAddr = 23'h1FD380; cpuRnW = 1'b1;
    ncpuAS = 1'b0; ncpuUDS = 1'b0; ncpuLDS = 1'b0;
    n = 0;
    while (ncpuDTACK !== 1'b0 && n < 40) begin
      @(negedge pixClk); n++;
    end
    check("rack_reached_ack", 32'(ncpuDTACK), 32'd0);
    @(posedge pixClk); #1 reset = 1'b1;
    @(posedge pixClk);
    @(negedge pixClk);
    check("rack_dtack", 32'(ncpuDTACK), 32'd1);
    check("rack_oe", 32'(cpuDataOE), 32'd0);
    check("rack_data", 32'(cpuDataOut), 32'd0);
    @(posedge pixClk); #1 reset = 1'b0;
    p0 = pulse_cnt;
    repeat (14) @(posedge pixClk);
    #1;
    check("rack_ignored_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("rack_ignored_dtack", 32'(ncpuDTACK), 32'd1);
    check("rack_ignored_idle", 32'(dut.r_state), 32'(IDLE));
    release_bus();
    repeat (3) @(posedge pixClk);
    #1;

    // Back-to-back reads, AS high 3 cycles between them.
    bus_cycle("b2b_first",  24'h3FA700, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA53C, 1'b0, 2, 15'd1);
    bus_cycle("b2b_second", 24'h3F2700, 1'b1, 1'b1, 1'b1, 1'b1, 16'h967E, 1'b1, 2, 15'd1);

    repeat (2) @(posedge pixClk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
